lsu_unit: RTL
=============

Name: lsu_unit

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result `e` as the effective address, plus rs2 store data and funct3.
- Drives a request/grant/rvalid data-memory port and returns sign- or zero-extended load data for writeback.
- Holds `busy` high while a transaction is outstanding, so the core stalls the PC and register writeback.

Parameters:
- ADDR_W, 32, effective address width (matches ALU `e`).
- DATA_W, 32, data width; only 32 is supported.
- TIMEOUT_CYCLES, 64, cycles in WAIT before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  core presents a memory op this cycle.
- is_load  in  1  op is a load.
- is_store  in  1  op is a store.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  effective address from ALU `e`.
- wdata  in  32  store data (rs2).
- busy  out  1  transaction in progress; core must stall.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on misaligned/illegal/timeout.
- rdata  out  32  extended load result; valid when done=1, held until the next done.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Clocking and reset:
  - One clock `clk`; reset `rst_n` is asynchronous, active-low.
  - Reset values: all outputs 0; state IDLE; internal registers 0.
  - Reset mid-transaction abandons it: no done, mem_req drops immediately.
- Accept: in IDLE, `valid` with exactly one of is_load/is_store captures funct3, addr, wdata and op type. valid while busy=1 is ignored.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Immediate error path (no memory access; goes to RESP; done=err=1 the next cycle):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Illegal funct3.
  - is_load and is_store both high.
- States: IDLE → REQ → (store) RESP / (load) WAIT → RESP → IDLE.
  - REQ:
    - mem_req=1, with mem_we/be/addr/wdata stable until mem_gnt.
    - On gnt: a store goes to RESP; a load goes to WAIT.
  - WAIT:
    - mem_req=0. On mem_rvalid, capture the extended data and go to RESP.
    - mem_rvalid outside WAIT is ignored; rvalid on the grant cycle is not legal for the memory.
  - RESP: done=1 for one cycle, then IDLE.
  - busy = (state≠IDLE).
- Minimum latency:
  - Store: accept at cycle 0, req in cycle 1 with gnt, done in cycle 2.
  - Load with rvalid in cycle 2: done in cycle 3.
- Byte enables: SB → 4'b0001<<addr[1:0]; SH → 4'b0011<<addr[1:0]; SW → 4'b1111.
- Store data: SB replicates wdata[7:0] ×4; SH replicates wdata[15:0] ×2; SW passes wdata.
- Load extract: select the byte/halfword via addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- On err: rdata=0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES elapse without mem_rvalid, go to RESP with done=err=1, rdata=0.
  - A late rvalid is ignored once back in IDLE.
- Undefined: WAIT persists indefinitely; no counter logic is synthesized.

Decomposition:
- lsu_pkg:
  - state enum lsu_state_t {IDLE, REQ, WAIT, RESP}.
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - function for byte-enable generation.
- Sub-module lsu_align: combinational store-lane steering and load extract/extension, shared by the store and load paths.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle → mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF, done in cycle 2, busy high for cycles 1–2.
- SB addr=0x103, wdata=0x000000A5 → be=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x202, mem_rdata=0x12F00000 (rvalid 3 cycles after gnt) → rdata=0xFFFFFFF0.
- LHU at 0x202 with the same mem_rdata → rdata=0x000012F0.
- LW addr=0x101 → no mem_req ever asserted; done=err=1 in cycle 1.
- LW with rvalid withheld (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8) → done=err=1 after 8 WAIT cycles, rdata=0.
- rst_n asserted low in WAIT → mem_req, busy and done low immediately; no done pulse after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Unsigned variants exist only for loads; alignment follows the access size.
  function automatic logic lsu_legal(input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [1:0] off);
    if (ld && st) return 1'b0;
    case (f3)
      F3_B:    return 1'b1;
      F3_BU:   return ld;
      F3_H:    return ~off[0];
      F3_HU:   return ld & ~off[0];
      F3_W:    return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/grant/rvalid port; master = LSU, slave = memory.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Store-lane replication and load byte/halfword extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};

    case (funct3[1:0])
      2'b00:   store_data = {4{wdata[7:0]}};
      2'b01:   store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase

    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = shifted;
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: ALU address -> data-memory transaction -> extended writeback data.
// Optional WAIT-state timeout is built when LSU_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | ready; accepts a load or store
// REQ   | mem_req held with stable attributes until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid (or timeout)
// RESP  | done (and err) pulse, then back to IDLE
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  lsu_if.master             mem
);

  if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("lsu_unit: DATA_W must be 32 and TIMEOUT_CYCLES at least 1");
  end

  lsu_state_t  state;
  logic        op_load;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_sel;
  logic [1:0]  off_sel;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        tmo_hit;

  // In IDLE the aligner serves the incoming store; afterwards the captured load.
  assign f3_sel  = (state == IDLE) ? funct3    : f3_q;
  assign off_sel = (state == IDLE) ? addr[1:0] : off_q;

  lsu_align u_align (
    .funct3     (f3_sel),
    .off        (off_sel),
    .wdata      (wdata),
    .mem_rdata  (mem.mem_rdata),
    .store_data (store_data),
    .load_data  (load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state == REQ) begin
      tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (state == WAIT && tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end

  assign tmo_hit = (state == WAIT) && (tmr == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_load       <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && (is_load || is_store)) begin
            busy    <= 1'b1;
            op_load <= is_load;
            f3_q    <= funct3;
            off_q   <= addr[1:0];
            if (lsu_legal(is_load, is_store, funct3, addr[1:0])) begin
              state         <= REQ;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= is_store;
              mem.mem_be    <= lsu_be(funct3, addr[1:0]);
              mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem.mem_wdata <= store_data;
            end else begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            mem.mem_req <= 1'b0;
            if (op_load) begin
              state <= WAIT;
            end else begin
              state <= RESP;
              done  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            state <= RESP;
            done  <= 1'b1;
            rdata <= load_data;
          end else if (tmo_hit) begin
            state <= RESP;
            done  <= 1'b1;
            err   <= 1'b1;
            rdata <= '0;
          end
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
